// File: rtl/dt_pkg.sv
// Shared constants, state and phase encodings for the distance-transform sequencer.
package dt_pkg;

   localparam int DT_IMG_W  = 128;
   localparam int DT_IMG_H  = 128;
   localparam int DT_STI_W  = 16;
   localparam int DT_ADDR_W = 14;
   localparam int DT_STI_AW = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LD_RD,
      S_LD_WR,
      S_FWD,
      S_BWD,
      S_FIN
   } state_t;

   typedef enum logic [1:0] {
      PH_IDLE = 2'd0,
      PH_LOAD = 2'd1,
      PH_FWD  = 2'd2,
      PH_BWD  = 2'd3
   } phase_t;

   function automatic phase_t phase_of(input state_t s);
      case (s)
         S_LD_RD, S_LD_WR: phase_of = PH_LOAD;
         S_FWD:            phase_of = PH_FWD;
         S_BWD:            phase_of = PH_BWD;
         default:          phase_of = PH_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/dt_pass_ctrl_if.sv
// Result-memory request bundle of one pass engine plus its hold line from the sequencer.
interface dt_eng_if;
   import dt_pkg::*;

   logic                 rst;
   logic [DT_ADDR_W-1:0] addr;
   logic [7:0]           wdat;
   logic                 rd;
   logic                 wr;
   logic                 done;

   modport master (input rst, output addr, wdat, rd, wr, done);
   modport slave  (output rst, input addr, wdat, rd, wr, done);
endinterface

// File: rtl/dt_load_unpack.sv
// Unpacks 1-bit/pixel sti words into one 8-bit result write per cycle.
// DT_LOAD_PREFETCH_EN: issue the next word read on the last bit of the current word.
module dt_load_unpack #(
   parameter int STI_W  = 16,
   parameter int STI_AW = 10,
   parameter int ADDR_W = 14,
   parameter int WORDS  = 1024
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr_i,
   input  logic              rd_st_i,
   input  logic              wr_st_i,
   input  logic [STI_W-1:0]  sti_di_i,
   output logic              sti_rd_o,
   output logic [STI_AW-1:0] sti_addr_o,
   output logic              ld_wr_o,
   output logic [ADDR_W-1:0] ld_addr_o,
   output logic [7:0]        ld_dat_o,
   output logic              word_end_o,
   output logic              last_o
);
   localparam int BW = $clog2(STI_W);
   localparam logic [BW-1:0]     BIT_LAST  = BW'(STI_W - 1);
   localparam logic [STI_AW-1:0] WORD_LAST = STI_AW'(WORDS - 1);

   logic [STI_AW-1:0] word_cnt_q, word_cnt_d;
   logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
   logic [STI_W-1:0]  word_reg_q, word_reg_d;
   logic [BW-1:0]     pix_idx;
   logic              pix;

   always_comb begin
      word_end_o = wr_st_i && (bit_cnt_q == BIT_LAST);
      last_o     = word_end_o && (word_cnt_q == WORD_LAST);
      pix_idx    = BIT_LAST - bit_cnt_q;
      // Bit 0 of a word is taken straight from the ROM bus; it lands in word_reg this cycle.
      pix        = (bit_cnt_q == '0) ? sti_di_i[STI_W-1] : word_reg_q[pix_idx];

      ld_wr_o    = wr_st_i;
      ld_addr_o  = wr_st_i ? {word_cnt_q, bit_cnt_q} : '0;
      ld_dat_o   = {7'd0, wr_st_i & pix};
      sti_rd_o   = rd_st_i;
      sti_addr_o = rd_st_i ? word_cnt_q : '0;
`ifdef DT_LOAD_PREFETCH_EN
      if (word_end_o && !last_o) begin
         sti_rd_o   = 1'b1;
         sti_addr_o = word_cnt_q + 1'b1;
      end
`endif

      word_cnt_d = word_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      word_reg_d = word_reg_q;
      if (clr_i) begin
         word_cnt_d = '0;
         bit_cnt_d  = '0;
      end else if (wr_st_i) begin
         bit_cnt_d = bit_cnt_q + 1'b1;
         if (bit_cnt_q == '0) word_reg_d = sti_di_i;
         if (word_end_o && !last_o) word_cnt_d = word_cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         word_cnt_q <= '0;
         bit_cnt_q  <= '0;
         word_reg_q <= '0;
      end else begin
         word_cnt_q <= word_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         word_reg_q <= word_reg_d;
      end
   end
endmodule

// File: rtl/dt_pass_ctrl.sv
// Sequencer: load sti image, run forward then backward pass, raise done; owns the result port.
// DT_LOAD_PREFETCH_EN selects the 16-cycle/word loader (LD_RD visited once per run).
module dt_pass_ctrl
   import dt_pkg::*;
#(
   parameter int IMG_W  = DT_IMG_W,
   parameter int IMG_H  = DT_IMG_H,
   parameter int STI_W  = DT_STI_W,
   parameter int ADDR_W = DT_ADDR_W,
   parameter int STI_AW = DT_STI_AW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic [1:0]        phase,
   output logic              sti_rd,
   output logic [STI_AW-1:0] sti_addr,
   input  logic [STI_W-1:0]  sti_di,
   output logic [ADDR_W-1:0] res_addr,
   output logic              res_rd,
   output logic              res_wr,
   output logic [7:0]        res_do,
   dt_eng_if.slave           fwd,
   dt_eng_if.slave           bwd
);
   state_t state_q, state_d;
   phase_t phase_q;
   logic   busy_q, done_q, fwd_rst_q, bwd_rst_q;
   logic   ld_clr, ld_wr, ld_word_end, ld_last;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_dat;

   assign ld_clr = start && (state_q == S_IDLE || state_q == S_FIN);

   dt_load_unpack #(
      .STI_W (STI_W),
      .STI_AW(STI_AW),
      .ADDR_W(ADDR_W),
      .WORDS (IMG_W * IMG_H / STI_W)
   ) u_load (
      .clk       (clk),
      .reset     (reset),
      .clr_i     (ld_clr),
      .rd_st_i   (state_q == S_LD_RD),
      .wr_st_i   (state_q == S_LD_WR),
      .sti_di_i  (sti_di),
      .sti_rd_o  (sti_rd),
      .sti_addr_o(sti_addr),
      .ld_wr_o   (ld_wr),
      .ld_addr_o (ld_addr),
      .ld_dat_o  (ld_dat),
      .word_end_o(ld_word_end),
      .last_o    (ld_last)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE, S_FIN: if (start) state_d = S_LD_RD;
         S_LD_RD:       state_d = S_LD_WR;
         S_LD_WR: begin
            if (ld_last) state_d = S_FWD;
`ifdef DT_LOAD_PREFETCH_EN
            else if (ld_word_end) state_d = S_LD_WR;
`else
            else if (ld_word_end) state_d = S_LD_RD;
`endif
         end
         S_FWD:   if (fwd.done) state_d = S_BWD;
         S_BWD:   if (bwd.done) state_d = S_FIN;
         default: state_d = S_IDLE;
      endcase
   end

   // Status and hold outputs are registered from the next state so they align with state_q.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         phase_q   <= PH_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         fwd_rst_q <= 1'b1;
         bwd_rst_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_of(state_d);
         busy_q    <= (state_d != S_IDLE) && (state_d != S_FIN);
         done_q    <= (state_d == S_FIN);
         fwd_rst_q <= (state_d != S_FWD);
         bwd_rst_q <= (state_d != S_BWD);
      end
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign phase   = phase_q;
   assign fwd.rst = fwd_rst_q;
   assign bwd.rst = bwd_rst_q;

   // Engines assume same-cycle memory, so the grant mux stays purely combinational.
   always_comb begin
      res_addr = '0;
      res_rd   = 1'b0;
      res_wr   = 1'b0;
      res_do   = '0;
      case (state_q)
         S_LD_WR: begin
            res_addr = ld_addr;
            res_wr   = ld_wr;
            res_do   = ld_dat;
         end
         S_FWD: begin
            res_addr = fwd.addr;
            res_rd   = fwd.rd;
            res_wr   = fwd.wr;
            res_do   = fwd.wdat;
         end
         S_BWD: begin
            res_addr = bwd.addr;
            res_rd   = bwd.rd;
            res_wr   = bwd.wr;
            res_do   = bwd.wdat;
         end
         default: ;
      endcase
   end
endmodule

// File: tb/tb_dt_pass_ctrl.sv
// Bench for dt_pass_ctrl: ROM and result-memory models, engine stubs, image reference model.
`timescale 1ns/1ps
module tb_dt_pass_ctrl;
   import dt_pkg::*;

   localparam int NPIX = 16384;
   localparam int NW   = 1024;
`ifdef DT_LOAD_PREFETCH_EN
   localparam int LOAD_CYC = 16385;
`else
   localparam int LOAD_CYC = 17408;
`endif

   logic        clk = 1'b0;
   logic        reset, start;
   logic        busy, done;
   logic [1:0]  phase;
   logic        sti_rd;
   logic [9:0]  sti_addr;
   logic [15:0] sti_di = '0;
   logic [13:0] res_addr;
   logic        res_rd, res_wr;
   logic [7:0]  res_do;

   dt_eng_if fwd_if();
   dt_eng_if bwd_if();

   dt_pass_ctrl dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .phase(phase),
      .sti_rd(sti_rd), .sti_addr(sti_addr), .sti_di(sti_di),
      .res_addr(res_addr), .res_rd(res_rd), .res_wr(res_wr), .res_do(res_do),
      .fwd(fwd_if), .bwd(bwd_if)
   );

   logic [15:0] rom [NW];
   logic [7:0]  mem [NPIX];
   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) if (sti_rd) sti_di <= rom[sti_addr];
   always @(posedge clk) if (res_wr) mem[res_addr] <= res_do;

   // Reference pixel: bit 15 of each word is its leftmost pixel, stored as 0 or 1.
   function automatic logic [7:0] exp_pix(input int a);
      logic [15:0] w;
      w = rom[a / 16];
      return w[15 - (a % 16)] ? 8'd1 : 8'd0;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic quiet_engines();
      fwd_if.addr = '0; fwd_if.wdat = '0; fwd_if.rd = 0; fwd_if.wr = 0; fwd_if.done = 0;
      bwd_if.addr = '0; bwd_if.wdat = '0; bwd_if.rd = 0; bwd_if.wr = 0; bwd_if.done = 0;
   endtask

   task automatic start_pulse();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_fwd(input string tag);
      int cyc = 0;
      while (phase !== 2'd2 && cyc < 20000) begin
         tick();
         cyc++;
      end
      n_cmp++;
      if (cyc != LOAD_CYC || phase !== 2'd2) begin
         n_err++;
         $display("FAIL %s_load_time: got %0d cycles phase=%0d, want %0d cycles phase=2",
                  tag, cyc, phase, LOAD_CYC);
      end
   endtask

   task automatic check_image(input string tag);
      int bad = 0;
      int first = -1;
      for (int a = 0; a < NPIX; a++) begin
         if (mem[a] !== exp_pix(a)) begin
            if (first < 0) first = a;
            bad++;
         end
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL %s_image: %0d bad pixels, first at %0d got %0d want %0d",
                  tag, bad, first, mem[first], exp_pix(first));
      end
   endtask

   task automatic test_reset();
      start = 0;
      reset = 1;
      quiet_engines();
      tick();
      tick();
      n_cmp++;
      if ({busy, done, phase, sti_rd, sti_addr, res_addr, res_rd, res_wr, res_do,
           fwd_if.rst, bwd_if.rst} !== {1'b0, 1'b0, 2'd0, 1'b0, 10'd0, 14'd0, 1'b0, 1'b0, 8'd0,
           1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL reset_state: busy=%b done=%b phase=%0d sti_rd=%b res_wr=%b fwd_rst=%b bwd_rst=%b",
                  busy, done, phase, sti_rd, res_wr, fwd_if.rst, bwd_if.rst);
      end
      reset = 0;
      tick();
      n_cmp++;
      if (phase !== 2'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL idle_hold: phase=%0d busy=%b want 0/0", phase, busy);
      end
   endtask

   task automatic test_load_contents();
      int bad = 0;
      for (int i = 0; i < NW; i++) rom[i] = 16'h0000;
      rom[0]    = 16'h8001;
      rom[1023] = 16'hFFFF;
      start_pulse();
      n_cmp++;
      if (phase !== 2'd1 || busy !== 1'b1 || sti_rd !== 1'b1 || sti_addr !== 10'd0) begin
         n_err++;
         $display("FAIL load_first_read: phase=%0d busy=%b sti_rd=%b sti_addr=%0d want 1/1/1/0",
                  phase, busy, sti_rd, sti_addr);
      end
      wait_fwd("first");
      n_cmp++;
      if (mem[0] !== 8'd1 || mem[15] !== 8'd1) begin
         n_err++;
         $display("FAIL load_corners: res[0]=%0d res[15]=%0d want 1/1", mem[0], mem[15]);
      end
      for (int a = 1; a < 15; a++) if (mem[a] !== 8'd0) bad++;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL load_inner: %0d of res[1..14] nonzero, want 0", bad);
      end
      bad = 0;
      for (int a = 16368; a < NPIX; a++) if (mem[a] !== 8'd1) bad++;
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL load_tail: %0d of res[16368..16383] not 1, want 0", bad);
      end
      check_image("first");
   endtask

   task automatic test_grant_isolation();
      bwd_if.addr = 14'd5;
      bwd_if.wr   = 1'b1;
      bwd_if.wdat = 8'h5A;
      for (int i = 1; i <= 9; i++) begin
         fwd_if.addr = 14'($urandom);
         fwd_if.wdat = 8'($urandom);
         fwd_if.rd   = 1'($urandom);
         fwd_if.wr   = 1'($urandom);
         if (i == 4) bwd_if.done = 1'b1;
         #1;
         n_cmp++;
         if ({res_addr, res_rd, res_wr, res_do} !==
             {fwd_if.addr, fwd_if.rd, fwd_if.wr, fwd_if.wdat}) begin
            n_err++;
            $display("FAIL fwd_mux cycle %0d: addr=%0d rd=%b wr=%b do=%0d want %0d/%b/%b/%0d", i,
                     res_addr, res_rd, res_wr, res_do, fwd_if.addr, fwd_if.rd, fwd_if.wr, fwd_if.wdat);
         end
         tick();
         if (i == 4) begin
            bwd_if.done = 1'b0;
            n_cmp++;
            if (phase !== 2'd2) begin
               n_err++;
               $display("FAIL bwd_done_ignored: phase=%0d want 2", phase);
            end
         end
      end
   endtask

   task automatic test_handover();
      n_cmp++;
      if (fwd_if.rst !== 1'b0 || bwd_if.rst !== 1'b1) begin
         n_err++;
         $display("FAIL fwd_holds: fwd_rst=%b bwd_rst=%b want 0/1", fwd_if.rst, bwd_if.rst);
      end
      fwd_if.done = 1'b1;
      tick();
      fwd_if.done = 1'b0;
      n_cmp++;
      if (fwd_if.rst !== 1'b1 || bwd_if.rst !== 1'b0 || phase !== 2'd3) begin
         n_err++;
         $display("FAIL handover: fwd_rst=%b bwd_rst=%b phase=%0d want 1/0/3",
                  fwd_if.rst, bwd_if.rst, phase);
      end
   endtask

   task automatic test_busy_start();
      fwd_if.addr = 14'd7;
      fwd_if.wr   = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         bwd_if.addr = 14'($urandom);
         bwd_if.wdat = 8'($urandom);
         bwd_if.rd   = 1'($urandom);
         bwd_if.wr   = 1'($urandom);
         #1;
         n_cmp++;
         if ({res_addr, res_rd, res_wr, res_do} !==
             {bwd_if.addr, bwd_if.rd, bwd_if.wr, bwd_if.wdat}) begin
            n_err++;
            $display("FAIL bwd_mux cycle %0d: addr=%0d wr=%b want %0d/%b",
                     i, res_addr, res_wr, bwd_if.addr, bwd_if.wr);
         end
         if (i == 3) begin
            start_pulse();
            n_cmp++;
            if (phase !== 2'd3 || busy !== 1'b1 || sti_rd !== 1'b0) begin
               n_err++;
               $display("FAIL busy_start: phase=%0d busy=%b sti_rd=%b want 3/1/0", phase, busy, sti_rd);
            end
         end else begin
            tick();
         end
      end
   endtask

   task automatic test_completion();
      int bad = 0;
      bwd_if.wr   = 1'b1;
      bwd_if.done = 1'b1;
      tick();
      bwd_if.done = 1'b0;
      n_cmp++;
      if ({done, busy, phase, res_wr, res_rd, res_addr, res_do, fwd_if.rst, bwd_if.rst} !==
          {1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 14'd0, 8'd0, 1'b1, 1'b1}) begin
         n_err++;
         $display("FAIL fin_state: done=%b busy=%b phase=%0d res_wr=%b fwd_rst=%b bwd_rst=%b",
                  done, busy, phase, res_wr, fwd_if.rst, bwd_if.rst);
      end
      for (int i = 0; i < 100; i++) begin
         tick();
         if (done !== 1'b1 || phase !== 2'd0) bad++;
      end
      n_cmp++;
      if (bad != 0) begin
         n_err++;
         $display("FAIL done_held: %0d of 100 cycles without done, want 0", bad);
      end
      quiet_engines();
      for (int i = 0; i < NW; i++) rom[i] = 16'($urandom);
      start_pulse();
      n_cmp++;
      if (done !== 1'b0 || sti_rd !== 1'b1 || sti_addr !== 10'd0 || phase !== 2'd1) begin
         n_err++;
         $display("FAIL restart: done=%b sti_rd=%b sti_addr=%0d phase=%0d want 0/1/0/1",
                  done, sti_rd, sti_addr, phase);
      end
   endtask

   task automatic test_reset_midload();
      int k = 0;
      while (!(sti_rd === 1'b1 && sti_addr === 10'd300) && k < 20000) begin
         tick();
         k++;
      end
      n_cmp++;
      if (k >= 20000) begin
         n_err++;
         $display("FAIL reach_word300: sti_addr=%0d after %0d cycles, want 300", sti_addr, k);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      n_cmp++;
      if (phase !== 2'd0 || res_wr !== 1'b0 || busy !== 1'b0 || sti_rd !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL midload_reset: phase=%0d res_wr=%b busy=%b sti_rd=%b want 0/0/0/0",
                  phase, res_wr, busy, sti_rd);
      end
      for (int i = 0; i < NW; i++) rom[i] = 16'($urandom);
      tick();
      start_pulse();
      n_cmp++;
      if (sti_rd !== 1'b1 || sti_addr !== 10'd0) begin
         n_err++;
         $display("FAIL reload_word0: sti_rd=%b sti_addr=%0d want 1/0", sti_rd, sti_addr);
      end
      wait_fwd("reload");
      check_image("reload");
   endtask

   task automatic test_back_to_back();
      fwd_if.done = 1'b1;
      tick();
      fwd_if.done = 1'b0;
      bwd_if.done = 1'b1;
      tick();
      bwd_if.done = 1'b0;
      n_cmp++;
      if (done !== 1'b1 || phase !== 2'd0) begin
         n_err++;
         $display("FAIL b2b_done: done=%b phase=%0d want 1/0", done, phase);
      end
   endtask

   initial begin
      test_reset();
      test_load_contents();
      test_grant_isolation();
      test_handover();
      test_busy_start();
      test_completion();
      test_reset_midload();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/dt_pass_ctrl.md
# dt_pass_ctrl

Top-level sequencer for the distance-transform engine. On `start` it unpacks the 1-bit/pixel source image from the sti ROM into the 8-bit result memory. It then runs the forward pass engine and the backward pass engine, one after the other, and finally raises `done`. It owns the single result-memory port and grants it to exactly one agent at a time: the internal loader, the forward engine or the backward engine.

## Interface
Parameters:
- `IMG_W`, 128, image width in pixels
- `IMG_H`, 128, image height in pixels
- `STI_W`, 16, pixels per sti word
- `ADDR_W`, 14, result address width, log2(IMG_W*IMG_H)
- `STI_AW`, 10, sti address width, log2(IMG_W*IMG_H/STI_W)

Ports:
- `clk` in 1: single clock, rising edge
- `reset` in 1: synchronous, active-high
- `start` in 1: begin a run; sampled only in IDLE or FIN
- `busy` out 1: high in any load or pass state
- `done` out 1: high in FIN
- `phase` out 2: 0 idle/fin, 1 load, 2 forward, 3 backward
- `sti_rd` out 1: ROM read strobe
- `sti_addr` out STI_AW: ROM word address
- `sti_di` in STI_W: ROM data, valid one cycle after `sti_rd`
- `res_addr` out ADDR_W: memory address
- `res_rd` out 1: memory read strobe
- `res_wr` out 1: memory write strobe
- `res_do` out 8: memory write data
- `fwd_rst` out 1: high-active hold for the forward engine
- `fwd_addr`, `fwd_do`, `fwd_rd`, `fwd_wr`, `fwd_done` in: forward engine port request (ADDR_W, 8, 1, 1, 1)
- `bwd_rst` out 1: high-active hold for the backward engine
- `bwd_addr`, `bwd_do`, `bwd_rd`, `bwd_wr`, `bwd_done` in: backward engine port request (same widths)

`res_di` goes from the memory straight to the engines and does not pass through this block.

## Operation
States:
- **IDLE**
  - `start` → LD_RD
- **LD_RD**
  - `sti_rd`=1, `sti_addr`=word_cnt
  - next state: LD_WR
- **LD_WR**
  - Writes one pixel per cycle: `res_wr`=1, `res_addr`={word_cnt, bit_cnt}.
  - `res_do`=8'd1 if the pixel bit is 1, else 8'd0.
  - At bit_cnt=0 the pixel bit is `sti_di[15]`, and `sti_di` is captured into word_reg.
  - At bit_cnt>0 the pixel bit is word_reg[15-bit_cnt]. Bit 15 is the leftmost pixel.
  - bit_cnt=15 and word_cnt=1023 → FWD.
  - bit_cnt=15 otherwise → word_cnt+1, then LD_RD.
- **FWD**
  - `fwd_rst`=0; the res port mirrors the fwd_* request.
  - `fwd_done`=1 → BWD.
- **BWD**
  - `bwd_rst`=0; the res port mirrors the bwd_* request.
  - `bwd_done`=1 → FIN.
- **FIN**
  - `done`=1, held.
  - `start` → LD_RD; word_cnt and bit_cnt clear and `done` drops.

Rules:
- word_cnt is 10 bits and bit_cnt is 4 bits. Both wrap naturally and both clear on entry to LD_RD from IDLE or FIN.
- `fwd_rst`=1 in every state except FWD; `bwd_rst`=1 in every state except BWD.
- Requests and done strobes from an engine that is not granted are ignored.
- `start` is ignored while `busy`=1.
- In IDLE and FIN: `res_rd`=`res_wr`=0, `res_addr`=0, `res_do`=0.

## Timing
- Reset values: state IDLE; `busy`=`done`=0; `phase`=0; `sti_rd`=0; `sti_addr`=0; `res_*`=0; `fwd_rst`=`bwd_rst`=1.
- Reset mid-run returns the block to IDLE on the next edge. There is no partial flush.
- The res port in FWD and BWD is a combinational mux with zero added latency, because the engines expect same-cycle memory behaviour.
- The loader outputs come from state and counter registers.
- Load time without prefetch: 17 cycles/word, 17408 cycles total.
- The FWD state is entered on the edge after the write of address 16383.
- `fwd_done` and `bwd_done` may be one-cycle pulses or levels. The first cycle they are high advances the state.

## Configuration
- `DT_LOAD_PREFETCH_EN` defined:
  - In LD_WR with bit_cnt=15 and word_cnt<1023, the block also drives `sti_rd`=1 and `sti_addr`=word_cnt+1.
  - The next state is LD_WR with bit_cnt=0, skipping LD_RD.
  - Load time: 1 + 1024×16 = 16385 cycles.
- Undefined: the 17-cycle/word sequence above is used. LD_RD is visited for every word.

## Structure
- Shared package `dt_pkg`:
  - IMG_W, IMG_H, STI_W and the address widths
  - the state enum (IDLE, LD_RD, LD_WR, FWD, BWD, FIN)
  - the phase encoding
- Sub-module `dt_load_unpack` holds word_cnt, bit_cnt and word_reg, and drives the sti and loader write signals.
- The controller keeps the FSM, the engine hold outputs and the res-port mux.

## Test plan
- **Load contents:** ROM word 0=16'h8001 and all other words 0; pulse `start`.
  - Required: res[0]=1, res[15]=1, res[1..14]=0, all other addresses 0.
  - `phase`=2 after 17408 cycles, or 16385 with the macro.
- **Handover:** ROM word 1023=16'hFFFF; forward stub raises `fwd_done` 10 cycles after `fwd_rst` falls.
  - Required: res[16368..16383]=1.
  - `fwd_rst` rises and `bwd_rst` falls on the same edge; `phase`=3.
- **Grant isolation:** during FWD, drive `bwd_wr`=1 with `bwd_addr`=5.
  - Required: `res_wr` follows `fwd_wr` only.
  - A `bwd_done` pulse during FWD does not change state.
- **Completion and restart:** after `bwd_done`, `done`=1 and is held for 100 cycles. A `start` pulse in FIN drops `done` and `sti_rd`=1, `sti_addr`=0 on the next cycle.
- **Reset mid-load:** assert `reset` at word_cnt=300.
  - Required next cycle: IDLE, `res_wr`=0, `busy`=0.
  - A new `start` reloads from word 0.
- **Busy start:** a `start` pulse during BWD has no effect on state or counters.
